// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framing constants, RX FSM encoding and the
// byte-wide CRC-32 step used by both the RX checker and the TX FCS generator.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0] ETH_BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } eth_rx_state_t;

    // One byte of the reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ ETH_CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-CRC for one byte; the state register lives in the user.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_d8(crc_in, data);

endmodule

// File: rtl/eth_gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, streams dst MAC..payload with
// sof/eof marks, checks FCS/length/rx_er and hides the 4 FCS bytes behind a
// 5-byte delay line. Optional dst MAC filter: define ETH_RX_MAC_FILTER_EN.
module eth_gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter logic [47:0] LOCAL_MAC     = 48'h000A35000001
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rx_d,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic        rx_bad,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_err_cnt
);

`ifdef ETH_RX_MAC_FILTER_EN
    localparam bit MAC_FILTER = 1'b1;
`else
    localparam bit MAC_FILTER = 1'b0;
`endif

    // Byte counter saturates one past the max length, so it needs room for MAX+1.
    localparam int            CW      = $clog2(MAX_FRAME_LEN + 2);
    localparam logic [CW-1:0] HOLD    = CW'(5);
    localparam logic [CW-1:0] MIN_L   = CW'(MIN_FRAME_LEN);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_FRAME_LEN);
    localparam logic [CW-1:0] MAX_P1  = CW'(MAX_FRAME_LEN + 1);

    eth_rx_state_t   state;
    logic            prev_dv;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [31:0]     crc;
    logic [31:0]     crc_nxt;
    logic            er_seen;
    logic [4:0][7:0] dl;          // dl[4] is the oldest held byte
    logic            dv_rise;
    logic            mac_reject;
    logic            frame_ok;

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_rx_d),
        .crc_out (crc_nxt)
    );

    assign dv_rise = gmii_rx_dv && !prev_dv;
    assign cnt_inc = (cnt == MAX_P1) ? cnt : cnt + CW'(1);

    // Dst MAC check happens as the 6th byte arrives, i.e. just before the sof pop.
    assign mac_reject = MAC_FILTER && (state == ST_DATA) && gmii_rx_dv && (cnt == HOLD) &&
                        ({dl, gmii_rx_d} != LOCAL_MAC) && ({dl, gmii_rx_d} != ETH_BCAST_MAC);

    // Good-frame verdict evaluated in the cycle dv falls.
    assign frame_ok = (crc == ETH_CRC_RESIDUE) && (cnt >= MIN_L) && (cnt <= MAX_L) && !er_seen;

    // Framing FSM, delay line, CRC register, registered outputs and counters.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            // Track dv through reset so a frame already in flight is not seen as a new start.
            prev_dv     <= gmii_rx_dv;
            cnt         <= '0;
            crc         <= ETH_CRC_INIT;
            er_seen     <= 1'b0;
            dl          <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_sof      <= 1'b0;
            rx_eof      <= 1'b0;
            rx_good     <= 1'b0;
            rx_bad      <= 1'b0;
            frm_ok_cnt  <= '0;
            frm_err_cnt <= '0;
        end else begin
            prev_dv  <= gmii_rx_dv;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_good  <= 1'b0;
            rx_bad   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dv_rise) begin
                        cnt     <= '0;
                        crc     <= ETH_CRC_INIT;
                        er_seen <= 1'b0;
                        if (gmii_rx_d == ETH_PREAMBLE)  state <= ST_PREAMBLE;
                        else if (gmii_rx_d == ETH_SFD)  state <= ST_DATA;
                        else                            state <= ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        frm_err_cnt <= frm_err_cnt + 16'd1;
                        state       <= ST_IDLE;
                    end else if (gmii_rx_d == ETH_SFD) begin
                        state <= ST_DATA;
                    end else if (gmii_rx_d != ETH_PREAMBLE) begin
                        frm_err_cnt <= frm_err_cnt + 16'd1;
                        state       <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (gmii_rx_dv) begin
                        cnt <= cnt_inc;
                        crc <= crc_nxt;
                        dl  <= {dl[3:0], gmii_rx_d};
                        if (gmii_rx_er) er_seen <= 1'b1;
                        if (mac_reject) begin
                            state <= ST_DROP;
                        end else if (cnt >= HOLD) begin
                            rx_data  <= dl[4];
                            rx_valid <= 1'b1;
                            rx_sof   <= (cnt == HOLD);
                            if (cnt_inc == MAX_P1) begin
                                rx_eof      <= 1'b1;
                                rx_bad      <= 1'b1;
                                frm_err_cnt <= frm_err_cnt + 16'd1;
                                state       <= ST_DROP;
                            end
                        end
                    end else begin
                        state <= ST_IDLE;
                        // Only frames that already emitted sof get an eof; runts just count.
                        if (cnt > HOLD) begin
                            rx_data  <= dl[4];
                            rx_valid <= 1'b1;
                            rx_eof   <= 1'b1;
                            rx_good  <= frame_ok;
                            rx_bad   <= !frame_ok;
                            if (frame_ok) frm_ok_cnt  <= frm_ok_cnt + 16'd1;
                            else          frm_err_cnt <= frm_err_cnt + 16'd1;
                        end else begin
                            frm_err_cnt <= frm_err_cnt + 16'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_gmii_rx_framer.sv
// Randomized bench for eth_gmii_rx_framer against a frame-level reference model.
module tb_eth_gmii_rx_framer;

    localparam int          MIN_LEN = 64;
    localparam int          MAX_LEN = 1518;
    localparam logic [47:0] MY_MAC  = 48'h000A35000001;
    localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;
`ifdef ETH_RX_MAC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        gmii_rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rx_d = '0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_good, rx_bad;
    logic [15:0] frm_ok_cnt, frm_err_cnt;

    eth_gmii_rx_framer #(
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN),
        .LOCAL_MAC     (MY_MAC)
    ) dut (
        .gmii_rx_clk (gmii_rx_clk),
        .rst         (rst),
        .gmii_rx_d   (gmii_rx_d),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_good     (rx_good),
        .rx_bad      (rx_bad),
        .frm_ok_cnt  (frm_ok_cnt),
        .frm_err_cnt (frm_err_cnt)
    );

    always #4 gmii_rx_clk = ~gmii_rx_clk;

    // Edge counter: after edge k it reads k.
    int cyc = 0;
    always @(posedge gmii_rx_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;
    int stray = 0;
    int exp_ok = 0;
    int exp_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       sof, eof, good, bad;
        int         c;
    } obs_t;

    obs_t       oq[$];
    int         inc[$];      // capture edge of each frame byte
    logic [7:0] frm[$];      // frame bytes dst..FCS

    // Output monitor, sampled mid-cycle.
    always @(negedge gmii_rx_clk) begin
        if (!rst) begin
            if (rx_valid) oq.push_back('{rx_data, rx_sof, rx_eof, rx_good, rx_bad, cyc});
            else if (rx_sof || rx_eof || rx_good || rx_bad) stray++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic e, input logic [7:0] b);
        gmii_rx_dv = v;
        gmii_rx_er = e;
        gmii_rx_d  = b;
        @(posedge gmii_rx_clk);
        #1;
    endtask

    // FCS value as transmitted: inverted CRC-32 over the first len bytes of frm.
    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++)
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ frm[i][k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic build(input int n, input logic [47:0] dst);
        logic [31:0] f;
        frm.delete();
        if (n >= 10) begin
            for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
            while (frm.size() < n - 4) frm.push_back(8'($urandom));
            f = fcs_of(n - 4);
            for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
        end else begin
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
        end
    endtask

    // Drive frm with npre preamble bytes, predict the outcome, compare.
    task automatic run_frame(input int npre, input int er_at, input string tag);
        int          n, nd, idx, m;
        bit          egood;
        logic [47:0] dst;
        logic [31:0] rx_fcs;
        n = frm.size();
        nd = 0;
        egood = 0;
        dst = '0;
        if (n >= 6) dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        if (n <= 5) begin
            exp_err++;
        end else if (FILT && dst != MY_MAC && dst != BCAST) begin
            nd = 0;
        end else if (n > MAX_LEN) begin
            nd = MAX_LEN - 4;
            exp_err++;
        end else begin
            nd = n - 4;
            rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            egood = (n >= MIN_LEN) && !(er_at >= 1 && er_at <= n) && (fcs_of(n - 4) == rx_fcs);
            if (egood) exp_ok++;
            else       exp_err++;
        end

        oq.delete();
        inc.delete();
        for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) begin
            inc.push_back(cyc + 1);
            step(1'b1, (i + 1 == er_at), frm[i]);
        end
        repeat (10) step(1'b0, 1'b0, 8'h00);

        chk({tag, "/nout"}, 64'(oq.size()), 64'(nd));
        m = (oq.size() < nd) ? oq.size() : nd;
        if (m > 0) begin
            idx = m - 1;
            for (int i = 0; i < m; i++) begin
                if (oq[i].d !== frm[i] || oq[i].sof !== (i == 0) || oq[i].eof !== (i == nd - 1) ||
                    oq[i].good !== (i == nd - 1 && egood) || oq[i].bad !== (i == nd - 1 && !egood) ||
                    oq[i].c - inc[i] != 5) begin
                    idx = i;
                    break;
                end
            end
            chk({tag, "/data"}, oq[idx].d, frm[idx]);
            chk({tag, "/sof"},  oq[idx].sof, (idx == 0));
            chk({tag, "/eof"},  oq[idx].eof, (idx == nd - 1));
            chk({tag, "/good"}, oq[idx].good, (idx == nd - 1 && egood));
            chk({tag, "/bad"},  oq[idx].bad, (idx == nd - 1 && !egood));
            chk({tag, "/lat"},  64'(oq[idx].c - inc[idx]), 64'd5);
        end
        chk({tag, "/okcnt"},  frm_ok_cnt,  16'(exp_ok));
        chk({tag, "/errcnt"}, frm_err_cnt, 16'(exp_err));
    endtask

    initial begin
        int n, er_at, sel;
        logic [47:0] dst;

        // Reset state
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("rst/out", {rx_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_data}, '0);
        chk("rst/cnt", {frm_ok_cnt, frm_err_cnt}, '0);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 8'h00);

        // Directed frames
        build(64, MY_MAC);   run_frame(7, 0, "good64");
        build(64, MY_MAC);   frm[63] = frm[63] ^ 8'h01; run_frame(7, 0, "badfcs");
        build(64, MY_MAC);   run_frame(7, 20, "er20");
        build(1522, MY_MAC); run_frame(7, 0, "long1522");
        build(1518, BCAST);  run_frame(3, 0, "max1518");
        build(1519, MY_MAC); run_frame(1, 0, "over1519");
        build(63, MY_MAC);   run_frame(7, 0, "short63");
        build(3, MY_MAC);    run_frame(7, 0, "runt3");
        build(5, MY_MAC);    run_frame(0, 0, "runt5");
        build(0, MY_MAC);    run_frame(0, 0, "empty");

        // Preamble error by bad byte, then by dv drop
        oq.delete();
        step(1'b1, 1'b0, 8'h55); step(1'b1, 1'b0, 8'h55); step(1'b1, 1'b0, 8'hA5);
        repeat (5) step(1'b1, 1'b0, 8'($urandom));
        repeat (10) step(1'b0, 1'b0, 8'h00);
        exp_err++;
        step(1'b1, 1'b0, 8'h55); step(1'b1, 1'b0, 8'h55);
        repeat (10) step(1'b0, 1'b0, 8'h00);
        exp_err++;
        // Junk start byte: dropped silently
        step(1'b1, 1'b0, 8'h12);
        repeat (8) step(1'b1, 1'b0, 8'($urandom));
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("prerr/nout", 64'(oq.size()), 64'd0);
        chk("prerr/errcnt", frm_err_cnt, 16'(exp_err));
        chk("prerr/okcnt", frm_ok_cnt, 16'(exp_ok));

        // Reset in the middle of DATA; the tail must be ignored
        build(100, MY_MAC);
        repeat (7) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, frm[i]);
        rst = 1'b1;
        step(1'b1, 1'b0, frm[30]);
        step(1'b1, 1'b0, frm[31]);
        chk("midrst/out", {rx_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_data}, '0);
        chk("midrst/cnt", {frm_ok_cnt, frm_err_cnt}, '0);
        rst = 1'b0;
        exp_ok = 0;
        exp_err = 0;
        oq.delete();
        for (int i = 32; i < 100; i++) step(1'b1, 1'b0, frm[i]);
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("midrst/tail", 64'(oq.size()), 64'd0);
        chk("midrst/cnt2", {frm_ok_cnt, frm_err_cnt}, '0);
        build(64, MY_MAC);   run_frame(7, 0, "afterrst");

        // Address filter cases (all delivered when the filter is compiled out)
        build(64, MY_MAC);            run_frame(7, 0, "dst_local");
        build(64, BCAST);             run_frame(7, 0, "dst_bcast");
        build(64, 48'h0A0B0C0D0E0F);  run_frame(7, 0, "dst_other");

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 120));
            sel = $urandom_range(0, 2);
            dst = (sel == 0) ? MY_MAC : (sel == 1) ? BCAST : {$urandom, 16'($urandom)};
            build(n, dst);
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, n - 1);
                frm[sel] = frm[sel] ^ 8'(1 << $urandom_range(0, 7));
            end
            er_at = (n > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, n)) : 0;
            run_frame($urandom_range(0, 7), er_at, "rand");
        end

        chk("stray_flags", 64'(stray), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
